// File: rtl/membus_arbiter.sv
// N-to-1 round-robin arbiter for the membus valid/ready request channel.
// Grants are held across slave back-pressure, and responses are routed back through an in-order tag FIFO.
module membus_arbiter #(
   parameter int N_MASTERS       = 2,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_MASTERS-1:0]              m_valid,
   output logic [N_MASTERS-1:0]              m_ready,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_addr,
   input  logic [N_MASTERS-1:0]              m_wen,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_wdata,
   input  logic [N_MASTERS*DATA_WIDTH/8-1:0] m_wmask,
   output logic [N_MASTERS-1:0]              m_rvalid,
   output logic [DATA_WIDTH-1:0]             m_rdata,
   output logic                              s_valid,
   output logic [ADDR_WIDTH-1:0]             s_addr,
   output logic                              s_wen,
   output logic [DATA_WIDTH-1:0]             s_wdata,
   output logic [DATA_WIDTH/8-1:0]           s_wmask,
   input  logic                              s_ready,
   input  logic                              s_rvalid,
   input  logic [DATA_WIDTH-1:0]             s_rdata,
   output logic                              err
);

   localparam int ID_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int MASK_W = DATA_WIDTH / 8;

   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_MASTERS - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

   logic [ID_W-1:0]  rr_ptr;
   logic             lock_vld;
   logic [ID_W-1:0]  lock_id;
   logic [ID_W-1:0]  tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic [ID_W-1:0]  grant;
   logic             grant_vld;
   logic             full;
   logic             handshake;
   logic             pop;
   logic [ID_W-1:0]  head_id;

   function automatic logic [ID_W-1:0] rotate_idx(input logic [ID_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= N_MASTERS) sum = sum - N_MASTERS;
      return ID_W'(sum);
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   // Scan from the highest offset down so the closest requester to rr_ptr wins.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      if (lock_vld) begin
         grant     = lock_id;
         grant_vld = m_valid[lock_id];
      end else begin
         for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (m_valid[rotate_idx(rr_ptr, k)]) begin
               grant     = rotate_idx(rr_ptr, k);
               grant_vld = 1'b1;
            end
         end
      end
   end

   assign full      = (count == MAX_CNT);
   assign s_valid   = !rst && grant_vld && !full;
   assign handshake = s_valid && s_ready;
   assign pop       = !rst && s_rvalid && (count != '0);
   assign head_id   = tag_mem[rd_ptr];

   assign s_addr  = m_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
   assign s_wen   = m_wen[grant];
   assign s_wdata = m_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
   assign s_wmask = m_wmask[grant*MASK_W +: MASK_W];
   assign m_rdata = s_rdata;

   always_comb begin
      m_ready = '0;
      if (s_valid) m_ready[grant] = s_ready;
   end

   always_comb begin
      m_rvalid = '0;
      if (pop) m_rvalid[head_id] = 1'b1;
   end

   // Tag storage needs no reset: entries are only read while count says they are live.
   always_ff @(posedge clk) begin
      if (!rst && handshake) tag_mem[wr_ptr] <= grant;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         lock_vld <= 1'b0;
         lock_id  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         err      <= 1'b0;
      end else begin
         if (handshake) begin
            wr_ptr   <= next_ptr(wr_ptr);
            rr_ptr   <= (grant == LAST_ID) ? '0 : grant + 1'b1;
            lock_vld <= 1'b0;
         end else if (s_valid) begin
            lock_vld <= 1'b1;
            lock_id  <= grant;
         end else if (lock_vld && (!m_valid[lock_id] || full)) begin
            lock_vld <= 1'b0;
         end

         if (pop) rd_ptr <= next_ptr(rd_ptr);

         if (handshake && !pop) begin
            count <= count + 1'b1;
         end else if (!handshake && pop) begin
            count <= count - 1'b1;
         end

         // A response with nothing outstanding is dropped and flagged until reset.
         if (s_rvalid && (count == '0)) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_membus_arbiter.sv
// Scoreboard bench for membus_arbiter: directed stimulus queues expected grants and responses,
// and a negedge monitor pops and compares them whenever the DUT presents a handshake or an rvalid.
module tb_membus_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MO = 2;

   typedef struct {
      int          id;
      logic [31:0] addr;
      logic        wen;
   } grantExp_t;

   typedef struct {
      int          id;
      logic [31:0] data;
   } respExp_t;

   logic              clk;
   logic              rst;
   logic [N-1:0]      m_valid;
   logic [N-1:0]      m_ready;
   logic [N*AW-1:0]   m_addr;
   logic [N-1:0]      m_wen;
   logic [N*DW-1:0]   m_wdata;
   logic [N*DW/8-1:0] m_wmask;
   logic [N-1:0]      m_rvalid;
   logic [DW-1:0]     m_rdata;
   logic              s_valid;
   logic [AW-1:0]     s_addr;
   logic              s_wen;
   logic [DW-1:0]     s_wdata;
   logic [DW/8-1:0]   s_wmask;
   logic              s_ready;
   logic              s_rvalid;
   logic [DW-1:0]     s_rdata;
   logic              err;

   int nChecks = 0;
   int nFail   = 0;
   grantExp_t expGrants[$];
   respExp_t  expResps[$];

   membus_arbiter #(
      .N_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
      .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .s_valid(s_valid), .s_addr(s_addr), .s_wen(s_wen), .s_wdata(s_wdata),
      .s_wmask(s_wmask), .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
      .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, then return at the falling edge.
   task automatic applyStimulus(input logic rstV, input logic [N-1:0] validV, input logic readyV,
                                input logic rvalidV, input logic [31:0] rdataV);
      @(posedge clk);
      #1;
      rst      = rstV;
      m_valid  = validV;
      s_ready  = readyV;
      s_rvalid = rvalidV;
      s_rdata  = rdataV;
      @(negedge clk);
   endtask

   task automatic setPayload(input int id, input logic [31:0] addr, input logic wen, input logic [31:0] wdata);
      m_addr[id*AW +: AW]     = addr;
      m_wen[id]               = wen;
      m_wdata[id*DW +: DW]    = wdata;
      m_wmask[id*DW/8 +: DW/8] = 4'hF;
   endtask

   function automatic logic [31:0] baseAddr(input int id);
      return 32'h1000 + 32'(id) * 32'h10;
   endfunction

   task automatic expectGrant(input int id, input logic [31:0] addr, input logic wen);
      grantExp_t g;
      g.id = id; g.addr = addr; g.wen = wen;
      expGrants.push_back(g);
   endtask

   task automatic expectResp(input int id, input logic [31:0] data);
      respExp_t r;
      r.id = id; r.data = data;
      expResps.push_back(r);
   endtask

   always @(negedge clk) begin
      if (s_valid && s_ready) begin
         if (expGrants.size() == 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL unexpected_handshake: actual m_ready 0x%0h, required no handshake", m_ready);
         end else begin
            grantExp_t g;
            g = expGrants.pop_front();
            checkOutput("grant_ready", 64'(m_ready), 64'(1) << g.id);
            checkOutput("grant_addr", 64'(s_addr), 64'(g.addr));
            checkOutput("grant_wen", 64'(s_wen), 64'(g.wen));
         end
      end
      if (m_rvalid != '0) begin
         if (expResps.size() == 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL unexpected_rvalid: actual m_rvalid 0x%0h, required none", m_rvalid);
         end else begin
            respExp_t r;
            r = expResps.pop_front();
            checkOutput("resp_route", 64'(m_rvalid), 64'(1) << r.id);
            checkOutput("resp_data", 64'(m_rdata), 64'(r.data));
         end
      end
   end

   initial begin
      rst = 1'b1; m_valid = '0; s_ready = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
      m_addr = '0; m_wen = '0; m_wdata = '0; m_wmask = '0;
      for (int i = 0; i < N; i++) setPayload(i, baseAddr(i), 1'b0, 32'h0);

      // Reset with everyone requesting and the slave ready.
      repeat (3) begin
         applyStimulus(1'b1, 3'b111, 1'b1, 1'b0, 32'h0);
         checkOutput("reset_s_valid", 64'(s_valid), 64'h0);
         checkOutput("reset_m_ready", 64'(m_ready), 64'h0);
         checkOutput("reset_err", 64'(err), 64'h0);
      end

      // Round-robin under full contention, slave responding one cycle after each handshake.
      for (int c = 0; c <= 6; c++) begin
         if (c < 6) expectGrant(c % 3, baseAddr(c % 3), 1'b0);
         if (c >= 1) expectResp((c - 1) % 3, 32'hD000_0000 + 32'(c));
         applyStimulus(1'b0, (c < 6) ? 3'b111 : 3'b000, 1'b1, c >= 1, 32'hD000_0000 + 32'(c));
      end

      // Move rr_ptr to master 1 so the lock is what keeps master 0 on the bus.
      expectGrant(0, baseAddr(0), 1'b0);
      applyStimulus(1'b0, 3'b001, 1'b1, 1'b0, 32'h0);
      expectResp(0, 32'h11);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 32'h11);

      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, (c < 2) ? 3'b001 : 3'b011, 1'b0, 1'b0, 32'h0);
         checkOutput("lock_s_addr", 64'(s_addr), 64'(baseAddr(0)));
         checkOutput("lock_s_valid", 64'(s_valid), 64'h1);
      end
      expectGrant(0, baseAddr(0), 1'b0);
      applyStimulus(1'b0, 3'b011, 1'b1, 1'b0, 32'h0);
      expectGrant(1, baseAddr(1), 1'b0);
      expectResp(0, 32'h22);
      applyStimulus(1'b0, 3'b010, 1'b1, 1'b1, 32'h22);
      expectResp(1, 32'h33);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 32'h33);

      // FIFO full: two handshakes with no responses block the third request.
      expectGrant(0, baseAddr(0), 1'b0);
      applyStimulus(1'b0, 3'b001, 1'b1, 1'b0, 32'h0);
      expectGrant(0, baseAddr(0), 1'b0);
      applyStimulus(1'b0, 3'b001, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 3'b001, 1'b1, 1'b0, 32'h0);
      checkOutput("full_s_valid", 64'(s_valid), 64'h0);
      checkOutput("full_m_ready", 64'(m_ready), 64'h0);
      expectResp(0, 32'h44);
      applyStimulus(1'b0, 3'b001, 1'b1, 1'b1, 32'h44);
      checkOutput("full_no_bypass", 64'(s_valid), 64'h0);
      expectGrant(0, baseAddr(0), 1'b0);
      applyStimulus(1'b0, 3'b001, 1'b1, 1'b0, 32'h0);
      checkOutput("full_reassert", 64'(s_valid), 64'h1);
      expectResp(0, 32'h55);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 32'h55);
      expectResp(0, 32'h66);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 32'h66);

      // Pointer wrap: alternating masters 0 and 2, one push and one pop per cycle.
      for (int k = 0; k <= 10; k++) begin
         int idK;
         int idPrev;
         idK    = (k % 2 == 0) ? 0 : 2;
         idPrev = ((k - 1) % 2 == 0) ? 0 : 2;
         if (k < 10) expectGrant(idK, baseAddr(idK), 1'b0);
         if (k > 0) expectResp(idPrev, 32'hE00 + 32'(k));
         applyStimulus(1'b0, (k < 10) ? (3'b001 << idK) : 3'b000, 1'b1, k > 0, 32'hE00 + 32'(k));
      end

      // In-order routing: read from master 1, then write from master 0.
      setPayload(1, 32'h100, 1'b0, 32'h0);
      setPayload(0, 32'h200, 1'b1, 32'h1234_5678);
      expectGrant(1, 32'h100, 1'b0);
      applyStimulus(1'b0, 3'b010, 1'b1, 1'b0, 32'h0);
      expectGrant(0, 32'h200, 1'b1);
      applyStimulus(1'b0, 3'b001, 1'b1, 1'b0, 32'h0);
      checkOutput("write_data", 64'(s_wdata), 64'h1234_5678);
      expectResp(1, 32'hAAAA_5555);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 32'hAAAA_5555);
      expectResp(0, 32'h0);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 32'h0);
      checkOutput("no_err_yet", 64'(err), 64'h0);

      // Spurious response with nothing outstanding.
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 32'h77);
      checkOutput("spurious_m_rvalid", 64'(m_rvalid), 64'h0);
      repeat (3) begin
         applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 32'h0);
         checkOutput("err_sticky", 64'(err), 64'h1);
      end
      applyStimulus(1'b1, 3'b000, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 32'h0);
      checkOutput("err_cleared", 64'(err), 64'h0);

      // Reset with two requests outstanding, then a late response.
      expectGrant(0, 32'h200, 1'b1);
      applyStimulus(1'b0, 3'b001, 1'b1, 1'b0, 32'h0);
      expectGrant(1, 32'h100, 1'b0);
      applyStimulus(1'b0, 3'b010, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 3'b000, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 32'h99);
      checkOutput("late_m_rvalid", 64'(m_rvalid), 64'h0);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 32'h0);
      checkOutput("late_err", 64'(err), 64'h1);

      checkOutput("grants_drained", 64'(expGrants.size()), 64'h0);
      checkOutput("resps_drained", 64'(expResps.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
